// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared state type and default constants for the FIR channel scheduler
package fir_pkg;

  localparam int FIR_TAPS    = 64;
  localparam int FIR_NCH     = 4;
  localparam int FIR_DW      = 16;
  localparam int FIR_OW      = 38;
  // Generous bound: twice the tap count covers the engine fill plus drain.
  localparam int FIR_TIMEOUT = 2 * FIR_TAPS;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT    = 2'd2,
    ST_DELIVER = 2'd3
  } sched_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin picker, searches upward from last_grant+1
module rr_arbiter
  import fir_pkg::*;
#(
  parameter int NCH = FIR_NCH
) (
  input  logic [NCH-1:0]          req,
  input  logic [$clog2(NCH)-1:0]  last_grant,
  output logic [NCH-1:0]          grant,
  output logic [$clog2(NCH)-1:0]  grant_idx,
  output logic                    any
);

  localparam int IW = $clog2(NCH);

  logic [IW-1:0] cand;
  logic          found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    cand      = '0;
    found     = 1'b0;
    for (int k = 1; k <= NCH; k++) begin
      cand = IW'((int'(last_grant) + k) % NCH);
      if (!found && req[cand]) begin
        grant[cand] = 1'b1;
        grant_idx   = cand;
        found       = 1'b1;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/fir_channel_sched.sv
// rtl/fir_channel_sched.sv - round-robin scheduler sharing one FIR MAC engine among NCH channels
// Optional result timeout enabled by defining FIR_SCHED_TIMEOUT_EN.
module fir_channel_sched
  import fir_pkg::*;
#(
  parameter int NCH     = FIR_NCH,
  parameter int DW      = FIR_DW,
  parameter int OW      = FIR_OW,
  parameter int TIMEOUT = FIR_TIMEOUT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NCH-1:0]          ch_valid,
  input  logic [NCH*DW-1:0]       ch_data,
  output logic [NCH-1:0]          ch_ready,
  output logic                    fir_inputValid,
  output logic [DW-1:0]           fir_data,
  input  logic                    fir_outputValid,
  input  logic [OW-1:0]           fir_result,
  output logic                    res_valid,
  output logic [OW-1:0]           res_data,
  output logic [$clog2(NCH)-1:0]  res_ch,
  output logic                    res_err,
  input  logic                    res_ready
);

  localparam int IW = $clog2(NCH);

  sched_state_e  state_q;
  logic [IW-1:0] last_grant_q;
  logic [IW-1:0] res_ch_q;
  logic [DW-1:0] fir_data_q;
  logic [DW-1:0] fir_data_d;
  logic [OW-1:0] res_data_q;
  logic          fir_iv_q;
  logic          res_valid_q;
  logic          res_err_q;
  logic          timed_out;

  logic [NCH-1:0] grant;
  logic [IW-1:0]  grant_idx;
  logic           any_req;

  rr_arbiter #(.NCH(NCH)) u_arb (
    .req        (ch_valid),
    .last_grant (last_grant_q),
    .grant      (grant),
    .grant_idx  (grant_idx),
    .any        (any_req)
  );

  always_comb begin
    fir_data_d = '0;
    for (int k = 0; k < NCH; k++) begin
      if (grant[k]) fir_data_d = ch_data[k*DW +: DW];
    end
  end

`ifdef FIR_SCHED_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] wait_cnt_q;

  assign timed_out = (state_q == ST_WAIT) && (wait_cnt_q == CW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_q <= '0;
    end else if (state_q == ST_ISSUE) begin
      wait_cnt_q <= '0;
    end else if (state_q == ST_WAIT && !timed_out) begin
      wait_cnt_q <= wait_cnt_q + CW'(1);
    end
  end
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = TIMEOUT;
  assign timed_out      = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      last_grant_q <= IW'(NCH - 1);
      res_ch_q     <= '0;
      fir_data_q   <= '0;
      res_data_q   <= '0;
      fir_iv_q     <= 1'b0;
      res_valid_q  <= 1'b0;
      res_err_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (any_req) begin
            fir_data_q <= fir_data_d;
            res_ch_q   <= grant_idx;
            fir_iv_q   <= 1'b1;
            state_q    <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          fir_iv_q <= 1'b0;
          state_q  <= ST_WAIT;
        end
        ST_WAIT: begin
          // A real result beats a timeout landing in the same cycle.
          if (fir_outputValid) begin
            res_data_q  <= fir_result;
            res_err_q   <= 1'b0;
            res_valid_q <= 1'b1;
            state_q     <= ST_DELIVER;
          end else if (timed_out) begin
            res_data_q  <= '0;
            res_err_q   <= 1'b1;
            res_valid_q <= 1'b1;
            state_q     <= ST_DELIVER;
          end
        end
        ST_DELIVER: begin
          if (res_ready) begin
            res_valid_q  <= 1'b0;
            last_grant_q <= res_ch_q;
            state_q      <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Accept strobe is decoded live so the source sees it in the grant cycle.
  assign ch_ready       = (state_q == ST_IDLE) ? grant : '0;
  assign fir_inputValid = fir_iv_q;
  assign fir_data       = fir_data_q;
  assign res_valid      = res_valid_q;
  assign res_data       = res_data_q;
  assign res_ch         = res_ch_q;
  assign res_err        = res_err_q;

endmodule

// File: tb/tb_fir_channel_sched.sv
// tb/tb_fir_channel_sched.sv - self-checking bench for fir_channel_sched with a 66-cycle engine model
module tb_fir_channel_sched;

  localparam int NCH = 4;
  localparam int DW  = 16;
  localparam int OW  = 38;
  localparam int IW  = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NCH-1:0]    ch_valid = '0;
  logic [NCH*DW-1:0] ch_data = '0;
  logic [NCH-1:0]    ch_ready;
  logic              fir_inputValid;
  logic [DW-1:0]     fir_data;
  logic              fir_outputValid;
  logic [OW-1:0]     fir_result;
  logic              res_valid;
  logic [OW-1:0]     res_data;
  logic [IW-1:0]     res_ch;
  logic              res_err;
  logic              res_ready = 1'b0;

  logic              eng_ov = 1'b0;
  logic [OW-1:0]     eng_res = '0;
  logic              stray_ov = 1'b0;
  bit                eng_mute = 1'b0;
  bit                expect_err = 1'b0;
  int                eng_cnt = -1;
  logic [DW-1:0]     eng_d = '0;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc_n    = 0;

  typedef struct {
    int            ch;
    logic [OW-1:0] data;
    bit            err;
  } exp_t;

  exp_t sb_q[$];
  int   grant_log[$];
  int   grant_cyc[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc_n++;

  assign fir_outputValid = eng_ov | stray_ov;
  assign fir_result      = eng_ov ? eng_res : {OW{1'b1}};

  fir_channel_sched dut (
    .clk             (clk),
    .rst             (rst),
    .ch_valid        (ch_valid),
    .ch_data         (ch_data),
    .ch_ready        (ch_ready),
    .fir_inputValid  (fir_inputValid),
    .fir_data        (fir_data),
    .fir_outputValid (fir_outputValid),
    .fir_result      (fir_result),
    .res_valid       (res_valid),
    .res_data        (res_data),
    .res_ch          (res_ch),
    .res_err         (res_err),
    .res_ready       (res_ready)
  );

  function automatic logic [OW-1:0] eng_f(input logic [DW-1:0] d);
    return {d, ~d, 6'h2A};
  endfunction

  task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_n);
  endtask

  // Engine model: answers 66 cycles after the start pulse, forgets everything on reset.
  always @(negedge clk) begin
    eng_ov = 1'b0;
    if (rst) begin
      eng_cnt = -1;
    end else begin
      if (eng_cnt > 0) begin
        eng_cnt--;
        if (eng_cnt == 0) begin
          eng_ov  = 1'b1;
          eng_res = eng_f(eng_d);
          eng_cnt = -1;
        end
      end
      if (fir_inputValid && !eng_mute) begin
        eng_cnt = 66;
        eng_d   = fir_data;
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    int   idx;
    idx = 0;
    if (!rst && ch_ready != '0) begin
      chk($onehot(ch_ready), "ch_ready_onehot", 64'(ch_ready), 64'(ch_ready & -ch_ready));
      for (int k = 0; k < NCH; k++) if (ch_ready[k]) idx = k;
      e.ch   = idx;
      e.err  = expect_err;
      e.data = expect_err ? '0 : eng_f(ch_data[idx*DW +: DW]);
      sb_q.push_back(e);
      grant_log.push_back(idx);
      grant_cyc.push_back(cyc_n);
    end
    if (!rst && res_valid && res_ready) begin
      if (sb_q.size() == 0) begin
        chk(1'b0, "sb_unexpected_result", 64'(res_ch), 64'hFFFF);
      end else begin
        e = sb_q.pop_front();
        chk(res_ch == IW'(e.ch), "res_ch", 64'(res_ch), 64'(e.ch));
        chk(res_data == e.data, "res_data", 64'(res_data), 64'(e.data));
        chk(res_err == e.err, "res_err", 64'(res_err), 64'(e.err));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    #1;
    for (int n = 0; n < 20; n++) begin
      if (ch_ready != '0) begin
        ok = 1'b1;
        break;
      end
      cyc();
    end
  endtask

  task automatic wait_res(output int n);
    n = 0;
    while (!res_valid && n < 400) begin
      cyc();
      n++;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 400) begin
      cyc();
      n++;
    end
    chk(sb_q.size() == 0, "drain", 64'(sb_q.size()), 64'd0);
  endtask

  function automatic logic [62:0] all_outs();
    return {ch_ready, fir_inputValid, fir_data, res_valid, res_data, res_ch, res_err};
  endfunction

  typedef struct {
    logic [NCH-1:0] mask;
    logic [NCH-1:0] exp_ready;
  } vec_t;

  initial begin
    vec_t          vecs[8];
    bit            ok;
    int            lat;
    int            hold_bad;
    int            exp_idx;
    int            n;
    logic [DW-1:0] exp_d;
    logic [OW-1:0] held;

    // last_grant evolves across rows: 3 -> 2 -> 3 -> 0 -> 2 -> 0 -> 1 -> 0 -> 3
    vecs[0] = '{mask: 4'b0100, exp_ready: 4'b0100};
    vecs[1] = '{mask: 4'b1111, exp_ready: 4'b1000};
    vecs[2] = '{mask: 4'b1111, exp_ready: 4'b0001};
    vecs[3] = '{mask: 4'b0101, exp_ready: 4'b0100};
    vecs[4] = '{mask: 4'b0011, exp_ready: 4'b0001};
    vecs[5] = '{mask: 4'b1010, exp_ready: 4'b0010};
    vecs[6] = '{mask: 4'b0001, exp_ready: 4'b0001};
    vecs[7] = '{mask: 4'b1001, exp_ready: 4'b1000};

    rst = 1'b1;
    repeat (3) cyc();
    chk(all_outs() == '0, "reset_outputs", 64'(all_outs()), 64'd0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk(all_outs() == '0, "reset_idle", 64'(all_outs()), 64'd0);
    end

    res_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < NCH; k++) ch_data[k*DW +: DW] = DW'($urandom) | DW'(1);
      if (i == 0) ch_data[2*DW +: DW] = 16'h1234;
      ch_valid = vecs[i].mask;
      wait_ready(ok);
      chk(ok && ch_ready == vecs[i].exp_ready, "grant_vec", 64'(ch_ready), 64'(vecs[i].exp_ready));
      exp_idx = 0;
      for (int k = 0; k < NCH; k++) if (vecs[i].exp_ready[k]) exp_idx = k;
      exp_d = ch_data[exp_idx*DW +: DW];
      cyc();
      ch_valid = '0;
      chk(fir_inputValid == 1'b1, "issue_pulse", 64'(fir_inputValid), 64'd1);
      chk(fir_data == exp_d, "fir_data", 64'(fir_data), 64'(exp_d));
      cyc();
      chk(fir_inputValid == 1'b0, "issue_one_cycle", 64'(fir_inputValid), 64'd0);
      lat = 2;
      hold_bad = 0;
      while (!res_valid && lat < 300) begin
        if (fir_data != exp_d) hold_bad++;
        cyc();
        lat++;
      end
      chk(lat == 68, "latency", 64'(lat), 64'd68);
      chk(hold_bad == 0, "fir_data_hold", 64'(hold_bad), 64'd0);
      cyc();
      chk(res_valid == 1'b0, "deliver_one_cycle", 64'(res_valid), 64'd0);
    end

    // Backpressure with a stray engine strobe landing in DELIVER.
    res_ready = 1'b0;
    ch_data[1*DW +: DW] = 16'hBEEF;
    ch_valid = 4'b0010;
    wait_ready(ok);
    chk(ok && ch_ready == 4'b0010, "bp_grant", 64'(ch_ready), 64'h2);
    cyc();
    ch_valid = 4'b1111;
    wait_res(n);
    chk(res_valid == 1'b1, "bp_res_valid", 64'(res_valid), 64'd1);
    held = res_data;
    chk(held == eng_f(16'hBEEF), "bp_res_value", 64'(held), 64'(eng_f(16'hBEEF)));
    hold_bad = 0;
    for (int j = 0; j < 20; j++) begin
      if (!res_valid || res_data != held || ch_ready != '0) hold_bad++;
      if (j == 5) stray_ov = 1'b1;
      if (j == 6) stray_ov = 1'b0;
      cyc();
    end
    stray_ov = 1'b0;
    chk(hold_bad == 0, "bp_stall_stable", 64'(hold_bad), 64'd0);
    res_ready = 1'b1;
    cyc();
    chk(res_valid == 1'b0 && ch_ready == 4'b0100, "bp_next_grant", 64'(ch_ready), 64'h4);
    cyc();
    ch_valid = '0;
    wait_res(n);
    cyc();
    drain();

    // Reset 30 cycles into WAIT; the in-flight sample is discarded.
    ch_valid = 4'b1000;
    wait_ready(ok);
    chk(ok && ch_ready == 4'b1000, "rst_pre_grant", 64'(ch_ready), 64'h8);
    cyc();
    ch_valid = '0;
    cyc();
    repeat (30) cyc();
    rst = 1'b1;
    cyc();
    chk(all_outs() == '0, "mid_reset_outputs", 64'(all_outs()), 64'd0);
    cyc();
    rst = 1'b0;
    sb_q.delete();
    grant_log.delete();
    grant_cyc.delete();

    // Fairness with every channel requesting and the consumer always ready.
    ch_valid = 4'b1111;
    res_ready = 1'b1;
    n = 0;
    while (grant_log.size() < 6 && n < 1000) begin
      cyc();
      n++;
    end
    ch_valid = '0;
    chk(grant_log.size() == 6, "fair_count", 64'(grant_log.size()), 64'd6);
    for (int i = 0; i < grant_log.size() && i < 6; i++)
      chk(grant_log[i] == i % 4, "fair_order", 64'(grant_log[i]), 64'(i % 4));
    for (int i = 1; i < grant_cyc.size() && i < 6; i++)
      chk(grant_cyc[i] - grant_cyc[i-1] == 69, "fair_spacing", 64'(grant_cyc[i] - grant_cyc[i-1]), 64'd69);
    drain();

`ifdef FIR_SCHED_TIMEOUT_EN
    eng_mute = 1'b1;
    expect_err = 1'b1;
    ch_valid = 4'b0001;
    wait_ready(ok);
    chk(ok && ch_ready == 4'b0001, "to_grant", 64'(ch_ready), 64'h1);
    lat = 0;
    while (!res_valid && lat < 400) begin
      if (lat == 1) ch_valid = '0;
      cyc();
      lat++;
    end
    chk(lat == 130, "to_latency", 64'(lat), 64'd130);
    chk(res_err == 1'b1, "to_err", 64'(res_err), 64'd1);
    chk(res_data == '0, "to_data", 64'(res_data), 64'd0);
    cyc();
    expect_err = 1'b0;
    eng_mute = 1'b0;
    ch_valid = 4'b0100;
    wait_ready(ok);
    chk(ok && ch_ready == 4'b0100, "to_next_grant", 64'(ch_ready), 64'h4);
    cyc();
    ch_valid = '0;
    drain();
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc_n);
    $fatal(1, "watchdog");
  end

endmodule
